tdc_coarse_counter: RTL and testbench

TDC_COARSE_COUNTER -- requirements
Module: tdc_coarse_counter

---
 rtl/tdc_pkg.sv | 33 +++
 rtl/tdc_gray_counter.sv | 36 +++
 rtl/tdc_coarse_counter.sv | 163 ++++++++++++++++
 tb/tb_tdc_coarse_counter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// tdc_pkg: shared types and helpers for the TDC coarse counter.
//   tdc_state_e      : control FSM states
//   TDC_CNT_W        : default coarse count width
//   TDC_MAX_W        : widest count the gray helpers support
//   bin2gray/gray2bin: code conversions, zero-extended to TDC_MAX_W
package tdc_pkg;

    localparam int TDC_CNT_W = 16;
    localparam int TDC_MAX_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } tdc_state_e;

    function automatic logic [TDC_MAX_W-1:0] bin2gray(input logic [TDC_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Leading zeros from zero-extension leave the narrow result unchanged.
    function automatic logic [TDC_MAX_W-1:0] gray2bin(input logic [TDC_MAX_W-1:0] g);
        logic [TDC_MAX_W-1:0] b;
        b[TDC_MAX_W-1] = g[TDC_MAX_W-1];
        for (int i = TDC_MAX_W-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/tdc_gray_counter.sv
// tdc_gray_counter: ring-oscillator domain saturating gray counter.
//   i_ro_pulse : ring oscillator output, one tick per rising edge
//   i_clr_n    : async active-low clear (held low while the FSM is idle)
//   o_gray     : gray-coded tick count, saturates at all-ones binary
//   o_overflow : sticky, set by the tick that would have wrapped
module tdc_gray_counter
    import tdc_pkg::*;
#(
    parameter int CNT_W = TDC_CNT_W
) (
    input  logic             i_ro_pulse,
    input  logic             i_clr_n,
    output logic [CNT_W-1:0] o_gray,
    output logic             o_overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] bin_cur;
    logic [CNT_W-1:0] gray_nxt;

    assign bin_cur  = CNT_W'(gray2bin(TDC_MAX_W'(o_gray)));
    assign gray_nxt = CNT_W'(bin2gray(TDC_MAX_W'(bin_cur + CNT_W'(1))));

    always_ff @(posedge i_ro_pulse or negedge i_clr_n) begin
        if (!i_clr_n) begin
            o_gray     <= '0;
            o_overflow <= 1'b0;
        end else if (bin_cur == CNT_MAX) begin
            o_overflow <= 1'b1;
        end else begin
            o_gray <= gray_nxt;
        end
    end

endmodule

// File: rtl/tdc_coarse_counter.sv
// tdc_coarse_counter: coarse time-to-digital counter. Counts ring oscillator
// ticks from arm until an asynchronous stop edge, then hands the count over a
// valid/ready interface.
//   i_clk, i_nreset : system clock, async active-low reset
//   i_arm           : start a measurement (honoured only when idle)
//   i_stop          : async stop event, rising edge
//   i_ro_pulse      : ring oscillator ticks
//   o_ro_nreset     : ring oscillator enable, high only while armed and unstopped
//   o_busy          : measurement in progress
//   o_valid/i_ready : result handshake
//   o_count         : coarse tick count (binary)
//   o_overflow      : count saturated
//   o_timeout       : only with `define TDC_TIMEOUT_EN; result produced by the
//                     TIMEOUT_CYCLES watchdog rather than a stop edge
module tdc_coarse_counter
    import tdc_pkg::*;
#(
    parameter int CNT_W          = TDC_CNT_W,
    parameter int SETTLE         = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             i_clk,
    input  logic             i_nreset,
    input  logic             i_arm,
    input  logic             i_stop,
    input  logic             i_ro_pulse,
    output logic             o_ro_nreset,
    output logic             o_busy,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overflow
`ifdef TDC_TIMEOUT_EN
    ,
    output logic             o_timeout
`endif
);

    localparam int SC_W = $clog2(SETTLE + 1);

    if (SETTLE < 3 || CNT_W > TDC_MAX_W || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("tdc_coarse_counter: illegal parameter value");
    end

    tdc_state_e            state;
    logic                  ring_en;     // ring counter out of clear (not idle)
    logic                  armed_q;     // mirrors state == ST_ARMED, glitch-free
    logic                  stop_latch;
    logic [1:0]            stop_sync;
    logic [1:0][CNT_W-1:0] gray_sync;
    logic [1:0]            ovf_sync;
    logic [CNT_W-1:0]      ring_gray;
    logic                  ring_ovf;
    logic [SC_W-1:0]       settle_cnt;

    // Async controls come from dedicated flops, never from a state decode.
    wire ring_clr_n = i_nreset & ring_en;
    wire stop_clr_n = i_nreset & armed_q;

    assign o_ro_nreset = armed_q & ~stop_latch;

    // Stop edges outside ARMED are swallowed by the held-low clear.
    always_ff @(posedge i_stop or negedge stop_clr_n) begin
        if (!stop_clr_n) stop_latch <= 1'b0;
        else             stop_latch <= 1'b1;
    end

    tdc_gray_counter #(.CNT_W(CNT_W)) u_ring (
        .i_ro_pulse (i_ro_pulse),
        .i_clr_n    (ring_clr_n),
        .o_gray     (ring_gray),
        .o_overflow (ring_ovf)
    );

`ifdef TDC_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
    logic            to_flag;
`endif

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            state      <= ST_IDLE;
            ring_en    <= 1'b0;
            armed_q    <= 1'b0;
            o_busy     <= 1'b0;
            o_valid    <= 1'b0;
            o_count    <= '0;
            o_overflow <= 1'b0;
            stop_sync  <= '0;
            gray_sync  <= '0;
            ovf_sync   <= '0;
            settle_cnt <= '0;
`ifdef TDC_TIMEOUT_EN
            to_cnt     <= '0;
            to_flag    <= 1'b0;
            o_timeout  <= 1'b0;
`endif
        end else begin
            // Gray code makes the multi-bit ring count safe to resample; the
            // ring is already stopped by the time CAPTURE reads it.
            stop_sync <= {stop_sync[0], stop_latch};
            gray_sync <= {gray_sync[0], ring_gray};
            ovf_sync  <= {ovf_sync[0], ring_ovf};

            case (state)
                ST_IDLE: begin
                    if (i_arm) begin
                        state   <= ST_ARMED;
                        ring_en <= 1'b1;
                        armed_q <= 1'b1;
                        o_busy  <= 1'b1;
`ifdef TDC_TIMEOUT_EN
                        to_cnt    <= '0;
                        to_flag   <= 1'b0;
                        o_timeout <= 1'b0;
`endif
                    end
                end
                ST_ARMED: begin
                    settle_cnt <= '0;
                    if (stop_sync[1]) begin
                        state   <= ST_SETTLE;
                        armed_q <= 1'b0;
                    end
`ifdef TDC_TIMEOUT_EN
                    // Leaving ARMED drops o_ro_nreset exactly as a stop would.
                    else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state   <= ST_SETTLE;
                        armed_q <= 1'b0;
                        to_flag <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                ST_SETTLE: begin
                    if (settle_cnt == SC_W'(SETTLE - 1)) state <= ST_CAPTURE;
                    else                                 settle_cnt <= settle_cnt + SC_W'(1);
                end
                ST_CAPTURE: begin
                    o_count    <= CNT_W'(gray2bin(TDC_MAX_W'(gray_sync[1])));
                    o_overflow <= ovf_sync[1];
                    o_valid    <= 1'b1;
                    state      <= ST_DONE;
`ifdef TDC_TIMEOUT_EN
                    o_timeout  <= to_flag;
`endif
                end
                ST_DONE: begin
                    if (i_ready) begin
                        state   <= ST_IDLE;
                        o_valid <= 1'b0;
                        o_busy  <= 1'b0;
                        ring_en <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_coarse_counter.sv
// Bench for tdc_coarse_counter. Two instances (16-bit and 4-bit count) share
// all stimulus; the expected count is min(ticks, 2^W-1).
module tb_tdc_coarse_counter;

    localparam int SETTLE = 4;
    localparam int TO_CYC = 100;

    logic i_clk = 1'b0, i_nreset = 1'b0, i_arm = 1'b0, i_stop = 1'b0;
    logic i_ro_pulse = 1'b0, i_ready = 1'b0;

    logic        ro_a, busy_a, valid_a, ovf_a;
    logic [15:0] cnt_a;
    logic        ro_b, busy_b, valid_b, ovf_b;
    logic [3:0]  cnt_b;
`ifdef TDC_TIMEOUT_EN
    logic        to_a, to_b;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_ctr = 0;

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc_ctr <= cyc_ctr + 1;

    tdc_coarse_counter #(.CNT_W(16), .SETTLE(SETTLE), .TIMEOUT_CYCLES(TO_CYC)) u_dut (
        .i_clk(i_clk), .i_nreset(i_nreset), .i_arm(i_arm), .i_stop(i_stop),
        .i_ro_pulse(i_ro_pulse), .o_ro_nreset(ro_a), .o_busy(busy_a),
        .o_valid(valid_a), .i_ready(i_ready), .o_count(cnt_a), .o_overflow(ovf_a)
`ifdef TDC_TIMEOUT_EN
        , .o_timeout(to_a)
`endif
    );

    tdc_coarse_counter #(.CNT_W(4), .SETTLE(SETTLE), .TIMEOUT_CYCLES(TO_CYC)) u_dut4 (
        .i_clk(i_clk), .i_nreset(i_nreset), .i_arm(i_arm), .i_stop(i_stop),
        .i_ro_pulse(i_ro_pulse), .o_ro_nreset(ro_b), .o_busy(busy_b),
        .o_valid(valid_b), .i_ready(i_ready), .o_count(cnt_b), .o_overflow(ovf_b)
`ifdef TDC_TIMEOUT_EN
        , .o_timeout(to_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: a saturating count of the ticks seen while the ring ran.
    function automatic int exp_cnt(input int n, input int w);
        int mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic ro_pulses(input int n);
        repeat (n) begin
            i_ro_pulse = 1'b1; #2;
            i_ro_pulse = 1'b0; #2;
        end
    endtask

    task automatic arm_and_pulse(input int n, input string tag);
        @(negedge i_clk); i_arm = 1'b1;
        @(negedge i_clk); i_arm = 1'b0;
        chk({tag, ".busy"},  {30'd0, busy_a, busy_b}, 32'd3);
        chk({tag, ".ro_on"}, {30'd0, ro_a, ro_b},     32'd3);
        ro_pulses(n);
    endtask

    task automatic stop_and_wait(input string tag);
        int waited = 0;
        @(negedge i_clk); #1;
        i_stop = 1'b1; #1;
        chk({tag, ".ro_off"}, {30'd0, ro_a, ro_b}, 32'd0);
        #2 i_stop = 1'b0;
        while (!(valid_a && valid_b) && waited < SETTLE + 4) begin
            @(posedge i_clk); #1;
            waited++;
        end
        chk({tag, ".valid"}, {30'd0, valid_a, valid_b}, 32'd3);
    endtask

    task automatic check_result(input int n, input string tag);
        chk({tag, ".cnt16"}, 32'(cnt_a), 32'(exp_cnt(n, 16)));
        chk({tag, ".cnt4"},  32'(cnt_b), 32'(exp_cnt(n, 4)));
        chk({tag, ".ovf"},   {30'd0, ovf_a, ovf_b}, {30'd0, 1'b0, n > 15});
    endtask

    task automatic handshake(input string tag);
        @(negedge i_clk); i_ready = 1'b1;
        @(posedge i_clk); #1;
        chk({tag, ".idle"}, {28'd0, valid_a, valid_b, busy_a, busy_b}, 32'd0);
        @(negedge i_clk); i_ready = 1'b0;
    endtask

    task automatic measure(input int n, input string tag);
        arm_and_pulse(n, tag);
        stop_and_wait(tag);
        check_result(n, tag);
        handshake(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst.ctl", {28'd0, ro_a, busy_a, valid_a, ovf_a}, 32'd0);
        chk("rst.ctl4", {28'd0, ro_b, busy_b, valid_b, ovf_b}, 32'd0);
        chk("rst.cnt", {12'd0, cnt_b, cnt_a}, 32'd0);
        @(negedge i_clk); i_nreset = 1'b1;

        measure(37, "m37");
        measure(20, "m20");
        measure(0, "m0");

        // Stop edge while idle must not start anything.
        repeat (2) @(negedge i_clk);
        i_stop = 1'b1; #2 i_stop = 1'b0;
        repeat (10) @(posedge i_clk);
        #1 chk("idle_stop", {28'd0, valid_a, valid_b, busy_a, busy_b}, 32'd0);

        // Hold DONE with ready low and arm pulses.
        arm_and_pulse(12, "hold");
        stop_and_wait("hold");
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clk); i_arm = (k % 2 == 0);
            @(posedge i_clk); #1;
            chk("hold.valid", {30'd0, valid_a, valid_b}, 32'd3);
            chk("hold.cnt", 32'(cnt_a), 32'd12);
        end
        @(negedge i_clk); i_arm = 1'b0;
        handshake("hold");

        // Reset mid-measurement discards it.
        arm_and_pulse(10, "rstm");
        @(negedge i_clk); #1 i_nreset = 1'b0; #1;
        chk("rstm.ro",  {30'd0, ro_a, ro_b},     32'd0);
        chk("rstm.busy", {30'd0, busy_a, busy_b}, 32'd0);
        chk("rstm.cnt", 32'(cnt_a), 32'd0);
        @(negedge i_clk); i_nreset = 1'b1;
        measure(8, "m8");

        for (int r = 0; r < 10; r++) begin
            measure(int'($urandom_range(0, 40)), $sformatf("rnd%0d", r));
        end

`ifdef TDC_TIMEOUT_EN
        begin
            int t0, waited;
            @(negedge i_clk); i_arm = 1'b1;
            @(negedge i_clk); i_arm = 1'b0;
            t0 = cyc_ctr;
            ro_pulses(5);
            waited = 0;
            while (ro_a && waited < 2 * TO_CYC) begin
                @(negedge i_clk);
                waited++;
            end
            chk("to.cycles", 32'(cyc_ctr - t0), 32'(TO_CYC));
            waited = 0;
            while (!valid_a && waited < SETTLE + 6) begin
                @(negedge i_clk);
                waited++;
            end
            chk("to.valid", {30'd0, valid_a, valid_b}, 32'd3);
            chk("to.flag", {30'd0, to_a, to_b}, 32'd3);
            check_result(5, "to");
            handshake("to");
            @(negedge i_clk); i_arm = 1'b1;
            @(negedge i_clk); i_arm = 1'b0;
            chk("to.clr", {30'd0, to_a, to_b}, 32'd0);
            stop_and_wait("to2");
            check_result(0, "to2");
            handshake("to2");
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
